// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: fully associative victim cache for lines evicted from the
// direct-mapped main cache. A lookup hit streams the line back one word per
// cycle and then invalidates the entry, so a hit is exclusive.
// Optional feature: define VICTIM_PARITY_EN to store one even-parity bit per
// word and flag mismatches on readout through rd_parity_err.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting flush / lookup / insert (in that priority)
// READOUT | streaming the hit line, word offset rd_offset on rd_data
// INSERT  | capturing one ins_data word per cycle into the target entry
module victim_cache_ctrl #(
  parameter int ENTRIES    = 4,
  parameter int LINE_WORDS = 4,
  parameter int WORD_W     = 32,
  parameter int TAG_W      = 22
) (
  input  logic                          sysclk,
  input  logic                          nRESET,
  input  logic                          flush,
  input  logic                          lk_req,
  input  logic [TAG_W-1:0]              lk_tag,
  output logic                          lk_hit,
  output logic                          lk_miss,
  output logic                          rd_valid,
  output logic [WORD_W-1:0]             rd_data,
  output logic [$clog2(LINE_WORDS)-1:0] rd_offset,
  output logic                          rd_parity_err,
  input  logic                          ins_req,
  output logic                          ins_ready,
  input  logic [TAG_W-1:0]              ins_tag,
  input  logic [WORD_W-1:0]             ins_data,
  output logic                          ins_done,
  output logic                          busy,
  output logic [ENTRIES-1:0]            valid_vec,
  output logic [$clog2(ENTRIES)-1:0]    oldest
);

  localparam int IW = $clog2(ENTRIES);
  localparam int OW = $clog2(LINE_WORDS);
  localparam logic [OW-1:0] LAST_OFF = OW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READOUT = 2'd1,
    INSERT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Storage arrays carry no reset; only the valid bits qualify their contents.
  logic [WORD_W-1:0] mem  [ENTRIES][LINE_WORDS];
  logic [TAG_W-1:0]  tags [ENTRIES];
  logic [ENTRIES-1:0] valid;

  logic [IW-1:0]    cur_idx;
  logic [OW-1:0]    cnt;
  logic [TAG_W-1:0] ins_tag_q;

  logic          lk_match;
  logic [IW-1:0] lk_idx;
  logic          eq_found, inv_found;
  logic [IW-1:0] eq_idx, inv_idx;
  logic [IW-1:0] ins_tgt;
  logic          adv_oldest;

  logic          lk_fire, ins_fire, rd_last, ins_last;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [OW-1:0] wr_off;

  logic [IW-1:0]     rd_sel_idx;
  logic [OW-1:0]     rd_sel_off;
  logic [WORD_W-1:0] rd_sel_word;
  logic              rd_sel_perr;

  assign valid_vec = valid;
  assign busy      = (state != IDLE);
  assign ins_ready = (state == IDLE) && !lk_req && !flush;

  // Lookup match; scanning downward lets the lowest matching index win.
  always_comb begin
    lk_match = 1'b0;
    lk_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == lk_tag)) begin
        lk_match = 1'b1;
        lk_idx   = IW'(i);
      end
    end
  end

  // Insert target: same-tag entry, else lowest invalid, else round-robin victim.
  always_comb begin
    eq_found  = 1'b0;
    eq_idx    = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == ins_tag)) begin
        eq_found = 1'b1;
        eq_idx   = IW'(i);
      end
      if (!valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = IW'(i);
      end
    end
    adv_oldest = !eq_found && !inv_found;
    ins_tgt    = eq_found ? eq_idx : (inv_found ? inv_idx : oldest);
  end

  // State register.
  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and per-edge control strobes.
  always_comb begin
    state_nxt = state;
    lk_fire   = 1'b0;
    ins_fire  = 1'b0;
    rd_last   = 1'b0;
    ins_last  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && lk_req) begin
          lk_fire = 1'b1;
          if (lk_match) state_nxt = READOUT;
        end else if (ins_ready && ins_req) begin
          ins_fire  = 1'b1;
          state_nxt = INSERT;
        end
      end
      READOUT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (rd_offset == LAST_OFF) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      INSERT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == LAST_OFF) begin
          ins_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Array write port: word 0 lands at the accept edge, the rest follow in INSERT.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = cur_idx;
    wr_off = cnt;
    if (ins_fire) begin
      wr_en  = 1'b1;
      wr_idx = ins_tgt;
      wr_off = '0;
    end else if (state == INSERT && !flush) begin
      wr_en = 1'b1;
    end
  end

  // Word selected for the next readout cycle: offset 0 on a hit, else the next offset.
  always_comb begin
    if (state == IDLE) begin
      rd_sel_idx = lk_idx;
      rd_sel_off = '0;
    end else begin
      rd_sel_idx = cur_idx;
      rd_sel_off = OW'(rd_offset + 1'b1);
    end
  end
  assign rd_sel_word = mem[rd_sel_idx][rd_sel_off];

`ifdef VICTIM_PARITY_EN
  logic par [ENTRIES][LINE_WORDS];

  // Even-parity bit per stored word, written alongside the data.
  always_ff @(posedge sysclk) begin
    if (wr_en) par[wr_idx][wr_off] <= ^ins_data;
  end

  assign rd_sel_perr = (^rd_sel_word) ^ par[rd_sel_idx][rd_sel_off];
`else
  assign rd_sel_perr = 1'b0;
`endif

  // Data and tag storage; the tag is committed together with the last word.
  always_ff @(posedge sysclk) begin
    if (wr_en)    mem[wr_idx][wr_off] <= ins_data;
    if (ins_last) tags[cur_idx]       <= ins_tag_q;
  end

  // Valid bits, replacement pointer, readout pipeline and handshake pulses.
  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET) begin
      valid         <= '0;
      oldest        <= '0;
      cur_idx       <= '0;
      cnt           <= '0;
      ins_tag_q     <= '0;
      lk_hit        <= 1'b0;
      lk_miss       <= 1'b0;
      ins_done      <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_offset     <= '0;
      rd_parity_err <= 1'b0;
    end else begin
      lk_hit   <= 1'b0;
      lk_miss  <= 1'b0;
      ins_done <= 1'b0;
      if (flush) begin
        valid         <= '0;
        oldest        <= '0;
        rd_valid      <= 1'b0;
        rd_parity_err <= 1'b0;
      end else begin
        if (lk_fire) begin
          if (lk_match) begin
            lk_hit        <= 1'b1;
            cur_idx       <= lk_idx;
            rd_valid      <= 1'b1;
            rd_offset     <= '0;
            rd_data       <= rd_sel_word;
            rd_parity_err <= rd_sel_perr;
          end else begin
            lk_miss <= 1'b1;
          end
        end
        if (ins_fire) begin
          cur_idx        <= ins_tgt;
          valid[ins_tgt] <= 1'b0;
          cnt            <= OW'(1);
          ins_tag_q      <= ins_tag;
          if (adv_oldest) oldest <= IW'(oldest + 1'b1);
        end
        if (state == READOUT) begin
          if (rd_last) begin
            valid[cur_idx] <= 1'b0;
            rd_valid       <= 1'b0;
            rd_parity_err  <= 1'b0;
          end else begin
            rd_offset     <= rd_sel_off;
            rd_data       <= rd_sel_word;
            rd_parity_err <= rd_sel_perr;
          end
        end
        if (state == INSERT) begin
          if (ins_last) begin
            valid[cur_idx] <= 1'b1;
            ins_done       <= 1'b1;
          end else begin
            cnt <= OW'(cnt + 1'b1);
          end
        end
      end
    end
  end

endmodule
